// File: rtl/calc_arb_pkg.sv
// Shared types and helpers for the calc_arbiter slice.
// Holds default sizes, the requester tag type and the round-robin picker.
package calc_arb_pkg;

    localparam int CA_DATA_WIDTH   = 32;
    localparam int CA_N_REQ        = 2;
    localparam int CA_MAX_INFLIGHT = 4;
    localparam int TAG_W = (CA_N_REQ > 1) ? $clog2(CA_N_REQ) : 1;

    typedef logic [TAG_W-1:0] tag_t;

    typedef struct packed {
        logic found;
        tag_t idx;
    } pick_t;

    // Walk downward so the candidate nearest to prio is written last and wins.
    function automatic pick_t rr_pick(input logic [CA_N_REQ-1:0] valid,
                                      input tag_t prio);
        pick_t r;
        int    j;
        r = '0;
        for (int k = CA_N_REQ - 1; k >= 0; k--) begin
            j = (int'(prio) + k) % CA_N_REQ;
            if (valid[j]) begin
                r.found = 1'b1;
                r.idx   = tag_t'(j);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/calc_arbiter_tag_fifo.sv
// Tag FIFO recording the owner of each issued operation, in issue order.
// Power-of-2 depth with wrapping pointers and an explicit occupancy count.
module calc_tag_fifo
    import calc_arb_pkg::*;
#(
    parameter int DEPTH = CA_MAX_INFLIGHT
) (
    input  logic                     clk_i,
    input  logic                     artsn_i,
    input  logic                     push_i,
    input  tag_t                     din_i,
    input  logic                     pop_i,
    output tag_t                     dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);

    tag_t          mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    always_comb begin
        do_push = push_i & ~full_o;
        do_pop  = pop_i & ~empty_o;
        wr_d    = do_push ? wr_q + 1'b1 : wr_q;
        rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
        cnt_d   = cnt_q;
        if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
        if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!artsn_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_q];
    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/calc_arbiter.sv
// Round-robin front end sharing one calc datapath between requesters.
// Issues one operand set per cycle and routes results back by issue order.
module calc_arbiter
    import calc_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = CA_DATA_WIDTH,
    parameter int N_REQ        = CA_N_REQ,
    parameter int MAX_INFLIGHT = CA_MAX_INFLIGHT
) (
    input  logic                             clk_i,
    input  logic                             artsn_i,
    input  logic [N_REQ-1:0]                 req_valid_i,
    output logic [N_REQ-1:0]                 req_ready_o,
    input  logic [N_REQ-1:0][DATA_WIDTH-1:0] req_a_i,
    input  logic [N_REQ-1:0][DATA_WIDTH-1:0] req_b_i,
    input  logic [N_REQ-1:0][DATA_WIDTH-1:0] req_c_i,
    input  logic [N_REQ-1:0][DATA_WIDTH-1:0] req_d_i,
    output logic [DATA_WIDTH-1:0]            dp_a_o,
    output logic [DATA_WIDTH-1:0]            dp_b_o,
    output logic [DATA_WIDTH-1:0]            dp_c_o,
    output logic [DATA_WIDTH-1:0]            dp_d_o,
    output logic                             dp_a_valid_o,
    output logic                             dp_b_valid_o,
    output logic                             dp_c_valid_o,
    output logic                             dp_d_valid_o,
    input  logic [DATA_WIDTH-1:0]            dp_q_i,
    input  logic                             dp_q_valid_i,
    output logic [DATA_WIDTH-1:0]            res_q_o,
    output logic [N_REQ-1:0]                 res_valid_o,
    output logic                             busy_o,
    output logic                             err_o
);

    tag_t                    prio_q, prio_d;
    pick_t                   pick;
    logic                    grant;
    logic                    pop;
    logic                    fifo_full, fifo_empty;
    tag_t                    head;
    logic [$clog2(MAX_INFLIGHT):0] fifo_cnt;

    logic [DATA_WIDTH-1:0]   a_q, b_q, c_q, d_q;
    logic                    dpv_q;
    logic [DATA_WIDTH-1:0]   res_q_q;
    logic [N_REQ-1:0]        res_vld_q;
    logic                    err_q;

    // Grant is blocked while full; a same-cycle pop does not bypass.
    always_comb begin
        pick        = rr_pick(req_valid_i, prio_q);
        grant       = artsn_i & pick.found & ~fifo_full;
        req_ready_o = '0;
        if (grant) req_ready_o[pick.idx] = 1'b1;
        prio_d = prio_q;
        if (grant) begin
            prio_d = (int'(pick.idx) == N_REQ - 1) ? '0 : pick.idx + 1'b1;
        end
        pop = dp_q_valid_i & ~fifo_empty;
    end

    calc_tag_fifo #(
        .DEPTH (MAX_INFLIGHT)
    ) u_fifo (
        .clk_i   (clk_i),
        .artsn_i (artsn_i),
        .push_i  (grant),
        .din_i   (pick.idx),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    always_ff @(posedge clk_i) begin
        if (!artsn_i) begin
            prio_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            d_q       <= '0;
            dpv_q     <= 1'b0;
            res_q_q   <= '0;
            res_vld_q <= '0;
            err_q     <= 1'b0;
        end else begin
            prio_q <= prio_d;
            dpv_q  <= grant;
            if (grant) begin
                a_q <= req_a_i[pick.idx];
                b_q <= req_b_i[pick.idx];
                c_q <= req_c_i[pick.idx];
                d_q <= req_d_i[pick.idx];
            end
            res_vld_q <= '0;
            if (pop) begin
                res_q_q         <= dp_q_i;
                res_vld_q[head] <= 1'b1;
            end
            if (dp_q_valid_i && fifo_empty) err_q <= 1'b1;
        end
    end

    assign dp_a_o       = a_q;
    assign dp_b_o       = b_q;
    assign dp_c_o       = c_q;
    assign dp_d_o       = d_q;
    assign dp_a_valid_o = dpv_q;
    assign dp_b_valid_o = dpv_q;
    assign dp_c_valid_o = dpv_q;
    assign dp_d_valid_o = dpv_q;
    assign res_q_o      = res_q_q;
    assign res_valid_o  = res_vld_q;
    assign busy_o       = (fifo_cnt != '0);
    assign err_o        = err_q;

endmodule
